// File: rtl/riscvio2i_core_reorder_buffer.sv
// Control-side reorder buffer: slot allocation in issue order, delayed fill
// marking, in-order commit and youngest-writer dependency lookup per source.

module riscvio2i_core_rob_lookup #(
  parameter int ENTRIES   = 16,
  parameter int SLOT_BITS = 4
) (
  input  logic [SLOT_BITS-1:0]     head_i,
  input  logic [ENTRIES-1:0]       valid_i,
  input  logic [ENTRIES-1:0]       ready_i,
  input  logic [ENTRIES-1:0]       wen_i,
  input  logic [ENTRIES-1:0][4:0]  waddr_i,
  input  logic [4:0]               addr_i,
  output logic                     match_o,
  output logic                     ready_o,
  output logic [SLOT_BITS-1:0]     slot_o
);

  logic [SLOT_BITS-1:0] idx;

  // Walk oldest to youngest from head; the last hit is the youngest writer.
  always_comb begin
    match_o = 1'b0;
    ready_o = 1'b0;
    slot_o  = '0;
    idx     = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      idx = head_i + SLOT_BITS'(k);
      if ((addr_i != 5'd0) && valid_i[idx] && wen_i[idx] && (waddr_i[idx] == addr_i)) begin
        match_o = 1'b1;
        ready_o = ready_i[idx];
        slot_o  = idx;
      end
    end
  end

endmodule

module riscvio2i_core_reorder_buffer #(
  parameter int ENTRIES   = 16,
  parameter int SLOT_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_val,
  input  logic                 alloc_wen,
  input  logic [4:0]           alloc_waddr,
  output logic                 alloc_rdy,
  output logic [SLOT_BITS-1:0] alloc_slot,
  input  logic                 fill_val,
  input  logic [SLOT_BITS-1:0] fill_slot,
  output logic                 rob_fill_wen_Whl,
  output logic [SLOT_BITS-1:0] rob_fill_slot_Whl,
  output logic                 rob_commit_val_Chl,
  output logic                 rob_commit_wen_Chl,
  output logic [SLOT_BITS-1:0] rob_commit_slot_Chl,
  output logic [4:0]           rob_commit_waddr_Chl,
  input  logic [4:0]           src0_addr,
  input  logic [4:0]           src1_addr,
  output logic                 src0_match,
  output logic                 src1_match,
  output logic                 src0_ready,
  output logic                 src1_ready,
  output logic [SLOT_BITS-1:0] src0_slot,
  output logic [SLOT_BITS-1:0] src1_slot,
  output logic [SLOT_BITS:0]   count,
  output logic                 empty,
  output logic                 full
);

  localparam int NUM_SRC = 2;

  logic [SLOT_BITS-1:0]      head_q, head_d, tail_q, tail_d;
  logic [SLOT_BITS:0]        count_q, count_d;
  logic [ENTRIES-1:0]        valid_q, valid_d, ready_q, ready_d, wen_q, wen_d;
  logic [ENTRIES-1:0][4:0]   waddr_q, waddr_d;
  logic                      fill_wen_q, fill_wen_d;
  logic [SLOT_BITS-1:0]      fill_slot_q, fill_slot_d;

  logic                      commit_val, alloc_fire;

  logic [NUM_SRC-1:0][4:0]           src_addr;
  logic [NUM_SRC-1:0]                src_match, src_ready;
  logic [NUM_SRC-1:0][SLOT_BITS-1:0] src_slot;

  assign full       = (count_q == (SLOT_BITS+1)'(ENTRIES));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign alloc_rdy  = ~full;
  assign alloc_slot = tail_q;
  assign alloc_fire = alloc_val & ~full;

  assign commit_val           = valid_q[head_q] & ready_q[head_q];
  assign rob_commit_val_Chl   = commit_val;
  assign rob_commit_wen_Chl   = commit_val & wen_q[head_q];
  assign rob_commit_slot_Chl  = head_q;
  assign rob_commit_waddr_Chl = waddr_q[head_q];

  assign rob_fill_wen_Whl  = fill_wen_q;
  assign rob_fill_slot_Whl = fill_slot_q;

  // Fill, commit and alloc never collide: alloc targets an invalid slot,
  // and a committing head is already ready so a re-fill changes nothing.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    valid_d     = valid_q;
    ready_d     = ready_q;
    wen_d       = wen_q;
    waddr_d     = waddr_q;
    fill_wen_d  = fill_val;
    fill_slot_d = fill_slot;

    if (fill_wen_q && valid_q[fill_slot_q])
      ready_d[fill_slot_q] = 1'b1;

    if (commit_val) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end

    if (alloc_fire) begin
      valid_d[tail_q] = 1'b1;
      ready_d[tail_q] = 1'b0;
      wen_d[tail_q]   = alloc_wen & (alloc_waddr != 5'd0);
      waddr_d[tail_q] = alloc_waddr;
      tail_d          = tail_q + 1'b1;
    end

    case ({alloc_fire, commit_val})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      ready_q     <= '0;
      wen_q       <= '0;
      waddr_q     <= '0;
      fill_wen_q  <= 1'b0;
      fill_slot_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      ready_q     <= ready_d;
      wen_q       <= wen_d;
      waddr_q     <= waddr_d;
      fill_wen_q  <= fill_wen_d;
      fill_slot_q <= fill_slot_d;
    end
  end

  assign src_addr[0] = src0_addr;
  assign src_addr[1] = src1_addr;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_lookup
    riscvio2i_core_rob_lookup #(
      .ENTRIES  (ENTRIES),
      .SLOT_BITS(SLOT_BITS)
    ) u_lookup (
      .head_i (head_q),
      .valid_i(valid_q),
      .ready_i(ready_q),
      .wen_i  (wen_q),
      .waddr_i(waddr_q),
      .addr_i (src_addr[s]),
      .match_o(src_match[s]),
      .ready_o(src_ready[s]),
      .slot_o (src_slot[s])
    );
  end

  assign src0_match = src_match[0];
  assign src0_ready = src_ready[0];
  assign src0_slot  = src_slot[0];
  assign src1_match = src_match[1];
  assign src1_ready = src_ready[1];
  assign src1_slot  = src_slot[1];

endmodule

// File: tb/tb_riscvio2i_core_reorder_buffer.sv
// Directed bench for the reorder buffer: a cycle table for the basic
// alloc/fill/commit flow, then hand sequences for full, wrap, x0 and reset.

module tb_riscvio2i_core_reorder_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       alloc_val, alloc_wen;
  logic [4:0] alloc_waddr;
  logic       alloc_rdy;
  logic [3:0] alloc_slot;
  logic       fill_val;
  logic [3:0] fill_slot;
  logic       rob_fill_wen_Whl;
  logic [3:0] rob_fill_slot_Whl;
  logic       rob_commit_val_Chl, rob_commit_wen_Chl;
  logic [3:0] rob_commit_slot_Chl;
  logic [4:0] rob_commit_waddr_Chl;
  logic [4:0] src0_addr, src1_addr;
  logic       src0_match, src1_match, src0_ready, src1_ready;
  logic [3:0] src0_slot, src1_slot;
  logic [4:0] count;
  logic       empty, full;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscvio2i_core_reorder_buffer dut (
    .clk(clk), .reset(reset),
    .alloc_val(alloc_val), .alloc_wen(alloc_wen), .alloc_waddr(alloc_waddr),
    .alloc_rdy(alloc_rdy), .alloc_slot(alloc_slot),
    .fill_val(fill_val), .fill_slot(fill_slot),
    .rob_fill_wen_Whl(rob_fill_wen_Whl), .rob_fill_slot_Whl(rob_fill_slot_Whl),
    .rob_commit_val_Chl(rob_commit_val_Chl), .rob_commit_wen_Chl(rob_commit_wen_Chl),
    .rob_commit_slot_Chl(rob_commit_slot_Chl), .rob_commit_waddr_Chl(rob_commit_waddr_Chl),
    .src0_addr(src0_addr), .src1_addr(src1_addr),
    .src0_match(src0_match), .src1_match(src1_match),
    .src0_ready(src0_ready), .src1_ready(src1_ready),
    .src0_slot(src0_slot), .src1_slot(src1_slot),
    .count(count), .empty(empty), .full(full)
  );

  typedef struct {
    int av, aw, aa, fv, fs, s0, s1;
    int rdy, aslot, cv, cw, cslot, cwa, m0, r0, sl0, m1, r1, sl1, cnt, fw, fsl;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle();
    alloc_val = 0; alloc_wen = 0; alloc_waddr = 0;
    fill_val = 0; fill_slot = 0; src0_addr = 0; src1_addr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic alloc_one(input int waddr);
    @(negedge clk);
    idle();
    alloc_val = 1; alloc_wen = 1; alloc_waddr = waddr[4:0];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          av aw aa fv fs s0 s1  rdy as cv cw cs cwa m0 r0 s0 m1 r1 s1 cnt fw fsl
    vt[0] = '{0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0};
    vt[1] = '{1, 1, 5, 0, 0, 5, 0,  1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0};
    vt[2] = '{1, 1, 6, 0, 0, 5, 6,  1, 1, 0, 0, 0, 5,  1, 0, 0, 0, 0, 0, 1,  0, 0};
    vt[3] = '{1, 1, 7, 0, 0, 6, 7,  1, 2, 0, 0, 0, 5,  1, 0, 1, 0, 0, 0, 2,  0, 0};
    vt[4] = '{0, 0, 0, 1, 1, 7, 0,  1, 3, 0, 0, 0, 5,  1, 0, 2, 0, 0, 0, 3,  0, 0};
    vt[5] = '{0, 0, 0, 1, 0, 6, 5,  1, 3, 0, 0, 0, 5,  1, 0, 1, 1, 0, 0, 3,  1, 1};
    vt[6] = '{0, 0, 0, 0, 0, 6, 5,  1, 3, 0, 0, 0, 5,  1, 1, 1, 1, 0, 0, 3,  1, 0};
    vt[7] = '{0, 0, 0, 0, 0, 5, 7,  1, 3, 1, 1, 0, 5,  1, 1, 0, 1, 0, 2, 3,  0, 0};
    vt[8] = '{0, 0, 0, 0, 0, 5, 0,  1, 3, 1, 1, 1, 6,  0, 0, 0, 0, 0, 0, 2,  0, 0};
    vt[9] = '{0, 0, 0, 0, 0, 7, 0,  1, 3, 0, 0, 2, 7,  1, 0, 2, 0, 0, 0, 1,  0, 0};

    idle();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      alloc_val = vt[i].av[0]; alloc_wen = vt[i].aw[0]; alloc_waddr = vt[i].aa[4:0];
      fill_val = vt[i].fv[0]; fill_slot = vt[i].fs[3:0];
      src0_addr = vt[i].s0[4:0]; src1_addr = vt[i].s1[4:0];
      #1;
      chk($sformatf("v%0d alloc_rdy", i), alloc_rdy, vt[i].rdy);
      chk($sformatf("v%0d alloc_slot", i), alloc_slot, vt[i].aslot);
      chk($sformatf("v%0d commit_val", i), rob_commit_val_Chl, vt[i].cv);
      chk($sformatf("v%0d commit_wen", i), rob_commit_wen_Chl, vt[i].cw);
      chk($sformatf("v%0d commit_slot", i), rob_commit_slot_Chl, vt[i].cslot);
      chk($sformatf("v%0d commit_waddr", i), rob_commit_waddr_Chl, vt[i].cwa);
      chk($sformatf("v%0d src0_match", i), src0_match, vt[i].m0);
      chk($sformatf("v%0d src0_ready", i), src0_ready, vt[i].r0);
      chk($sformatf("v%0d src0_slot", i), src0_slot, vt[i].sl0);
      chk($sformatf("v%0d src1_match", i), src1_match, vt[i].m1);
      chk($sformatf("v%0d src1_ready", i), src1_ready, vt[i].r1);
      chk($sformatf("v%0d src1_slot", i), src1_slot, vt[i].sl1);
      chk($sformatf("v%0d count", i), count, vt[i].cnt);
      chk($sformatf("v%0d empty", i), empty, (vt[i].cnt == 0) ? 1 : 0);
      chk($sformatf("v%0d full", i), full, (vt[i].cnt == 16) ? 1 : 0);
      chk($sformatf("v%0d fill_wen", i), rob_fill_wen_Whl, vt[i].fw);
      chk($sformatf("v%0d fill_slot", i), rob_fill_slot_Whl, vt[i].fsl);
    end

    // Fill to full; overflow alloc ignored; full still blocks during a commit.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      alloc_one(10 + (k % 4));
      #1;
      chk($sformatf("full alloc_slot %0d", k), alloc_slot, k);
      chk($sformatf("full rdy %0d", k), alloc_rdy, 1);
    end
    alloc_one(20);
    #1;
    chk("full flag", full, 1);
    chk("full alloc_rdy", alloc_rdy, 0);
    chk("full count", count, 16);
    @(negedge clk);
    idle();
    fill_val = 1; fill_slot = 0;
    #1;
    chk("overflow count", count, 16);
    chk("overflow tail", alloc_slot, 0);
    @(negedge clk);
    idle();
    #1;
    chk("full commit early", rob_commit_val_Chl, 0);
    @(negedge clk);
    idle();
    alloc_val = 1; alloc_wen = 1; alloc_waddr = 21;
    #1;
    chk("full commit_val", rob_commit_val_Chl, 1);
    chk("full commit_waddr", rob_commit_waddr_Chl, 10);
    chk("full rdy during commit", alloc_rdy, 0);
    @(negedge clk);
    idle();
    #1;
    chk("after commit count", count, 15);
    chk("after commit rdy", alloc_rdy, 1);
    chk("after commit head", rob_commit_slot_Chl, 1);
    chk("after commit tail", alloc_slot, 0);

    // Walk head/tail to 14, then allocate across the wrap.
    do_reset();
    for (int k = 0; k < 14; k++) alloc_one(3);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      idle();
      fill_val = 1; fill_slot = k[3:0];
    end
    begin
      int n = 0;
      @(negedge clk);
      idle();
      #1;
      while (!empty && n < 20) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("drain empty", empty, 1);
    end
    chk("drain tail", alloc_slot, 14);
    chk("drain head", rob_commit_slot_Chl, 14);
    for (int k = 0; k < 3; k++) begin
      alloc_one(9);
      #1;
      chk($sformatf("wrap alloc_slot %0d", k), alloc_slot, (14 + k) % 16);
    end
    @(negedge clk);
    idle();
    fill_val = 1; fill_slot = 15;
    repeat (2) begin
      @(negedge clk);
      idle();
    end
    src0_addr = 9; src1_addr = 3;
    #1;
    chk("wrap src0_match", src0_match, 1);
    chk("wrap src0_slot", src0_slot, 0);
    chk("wrap src0_ready", src0_ready, 0);
    chk("wrap src1_match", src1_match, 0);
    chk("wrap commit_val", rob_commit_val_Chl, 0);
    chk("wrap count", count, 3);

    // x0 destination retires without a register write and never matches.
    do_reset();
    alloc_one(0);
    @(negedge clk);
    idle();
    fill_val = 1; fill_slot = 0; src0_addr = 0;
    #1;
    chk("x0 src0_match", src0_match, 0);
    chk("x0 count", count, 1);
    @(negedge clk);
    idle();
    @(negedge clk);
    idle();
    #1;
    chk("x0 commit_val", rob_commit_val_Chl, 1);
    chk("x0 commit_wen", rob_commit_wen_Chl, 0);
    chk("x0 commit_waddr", rob_commit_waddr_Chl, 0);

    // Reset with live slots and a fill in flight.
    do_reset();
    for (int k = 0; k < 5; k++) alloc_one(20 + k);
    @(negedge clk);
    idle();
    fill_val = 1; fill_slot = 2;
    @(negedge clk);
    idle();
    reset = 1;
    #1;
    chk("pre-reset fill_wen", rob_fill_wen_Whl, 1);
    chk("pre-reset count", count, 5);
    @(negedge clk);
    reset = 0;
    #1;
    chk("mid reset count", count, 0);
    chk("mid reset empty", empty, 1);
    chk("mid reset fill_wen", rob_fill_wen_Whl, 0);
    chk("mid reset commit_val", rob_commit_val_Chl, 0);
    chk("mid reset alloc_slot", alloc_slot, 0);
    for (int k = 0; k < 3; k++) alloc_one(7);
    repeat (2) begin
      @(negedge clk);
      idle();
    end
    src0_addr = 7;
    #1;
    chk("post reset src0_slot", src0_slot, 2);
    chk("post reset src0_ready", src0_ready, 0);
    chk("post reset commit_val", rob_commit_val_Chl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
